// File: rtl/matrix_operand_loader.sv
// ---------------------------------------------------------------------------
// matrix_operand_loader
//
// Purpose:
//   Serial-to-parallel feeder for the 2x2 combinational matrix multiplier.
//   Elements arrive one per transfer in the order
//   A00, A01, A10, A11, B00, B01, B10, B11 (row-major, A before B).
//   They are stored in eight operand registers. Once the set is complete,
//   the registers are held stable and flagged valid until the consumer
//   acknowledges them.
//
// Ports:
//   clk        single clock; all state updates on the rising edge
//   rst        synchronous active-high reset (highest priority)
//   clr        synchronous soft abort: drops any partial or held set;
//              the operand registers keep their values
//   in_data    element value (DW bits, stored verbatim)
//   in_valid   in_data is valid this cycle
//   in_ready   loader accepts an element this cycle (LOAD state, not in rst)
//   A00..A11   matrix A operands, registered
//   B00..B11   matrix B operands, registered
//   out_valid  all eight operands are loaded and stable (HOLD state)
//   out_ready  consumer has taken the operand set
//   elem_cnt   index of the next element to be written (0..7)
//
// Handshake semantics (both streams):
//   A transfer happens at a rising edge where valid and ready are both 1.
//   The ready/valid outputs of this block are decodes of registered state
//   only (plus rst gating on in_ready). They never depend combinationally
//   on in_valid or out_ready.
// ---------------------------------------------------------------------------
module matrix_operand_loader #(
    parameter int DW       = 4,
    parameter int NUM_ELEM = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] A00,
    output logic [DW-1:0] A01,
    output logic [DW-1:0] A10,
    output logic [DW-1:0] A11,
    output logic [DW-1:0] B00,
    output logic [DW-1:0] B01,
    output logic [DW-1:0] B10,
    output logic [DW-1:0] B11,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    elem_cnt
);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_ELEM - 1);

    state_t        state;
    state_t        state_next;
    logic [2:0]    cnt;
    logic [DW-1:0] opnd [NUM_ELEM];
    logic          in_fire;
    logic          out_fire;

    // Ready/valid are decoded from the registered state only.
    assign in_ready  = (state == LOAD) && !rst;
    assign out_valid = (state == HOLD);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Next-state logic. rst and clr are applied in the register process
    // because both override whatever this logic decides.
    always_comb begin
        state_next = state;
        case (state)
            LOAD: if (in_fire && (cnt == LAST_IDX)) state_next = HOLD;
            HOLD: if (out_fire)                     state_next = LOAD;
            default:                                state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= 3'd0;
            for (int i = 0; i < NUM_ELEM; i++) begin
                opnd[i] <= '0;
            end
        end else if (clr) begin
            // The operand registers are deliberately left alone. Any
            // handshake in this cycle is dropped.
            state <= LOAD;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            if (in_fire) begin
                opnd[cnt] <= in_data;
                // Wraps 7 -> 0 naturally on the final element of a set.
                cnt       <= cnt + 3'd1;
            end
        end
    end

    assign elem_cnt = cnt;

    assign A00 = opnd[0];
    assign A01 = opnd[1];
    assign A10 = opnd[2];
    assign A11 = opnd[3];
    assign B00 = opnd[4];
    assign B01 = opnd[5];
    assign B10 = opnd[6];
    assign B11 = opnd[7];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_matrix_operand_loader
//
// Purpose:
//   Self-checking bench for matrix_operand_loader. A behavioural model (an
//   operand array, a write index and a "set is held" flag) is advanced once
//   per clock from the stimulus. After every edge, all DUT outputs are
//   compared against the model. Directed steps follow the test plan, and a
//   randomized phase follows them. Multiplier products are formed from the
//   loaded operands and checked against hand-computed matrices.
// ---------------------------------------------------------------------------
module tb_matrix_operand_loader;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] A00, A01, A10, A11, B00, B01, B10, B11;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    elem_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [DW-1:0] m_ops [8];
    int            m_idx  = 0;
    bit            m_held = 1'b0;

    matrix_operand_loader #(.DW(DW), .NUM_ELEM(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A00      (A00),
        .A01      (A01),
        .A10      (A10),
        .A11      (A11),
        .B00      (B00),
        .B01      (B01),
        .B10      (B10),
        .B11      (B11),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .elem_cnt (elem_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One element of the 2x2 product, truncated to the multiplier's 8 bits.
    function automatic logic [7:0] dot(input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                                       input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        logic [7:0] p;
        p = 8'(a0) * 8'(b0) + 8'(a1) * 8'(b1);
        return p;
    endfunction

    // Advance the model with the inputs present at the coming edge.
    // rst beats clr, and clr beats both handshakes.
    task automatic model_edge();
        if (rst) begin
            foreach (m_ops[i]) m_ops[i] = '0;
            m_idx  = 0;
            m_held = 1'b0;
        end else if (clr) begin
            m_idx  = 0;
            m_held = 1'b0;
        end else if (m_held) begin
            if (out_ready) m_held = 1'b0;
        end else if (in_valid) begin
            m_ops[m_idx] = in_data;
            m_idx++;
            if (m_idx == 8) begin
                m_idx  = 0;
                m_held = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("in_ready",  in_ready,  (!m_held && !rst) ? 1 : 0);
        chk("out_valid", out_valid, m_held ? 1 : 0);
        chk("elem_cnt",  elem_cnt,  m_idx);
        chk("A00", A00, m_ops[0]);
        chk("A01", A01, m_ops[1]);
        chk("A10", A10, m_ops[2]);
        chk("A11", A11, m_ops[3]);
        chk("B00", B00, m_ops[4]);
        chk("B01", B01, m_ops[5]);
        chk("B10", B10, m_ops[6]);
        chk("B11", B11, m_ops[7]);
    endtask

    // One clock: model update, edge, settle, compare. The caller changes
    // inputs after this returns, i.e. 1 time unit after the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [DW-1:0] d, input logic v);
        in_data  = d;
        in_valid = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic stream(input logic [DW-1:0] d [8]);
        for (int i = 0; i < 8; i++) send(d[i], 1'b1);
    endtask

    task automatic release_set();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_product(input string tag, input logic [7:0] c00, input logic [7:0] c01,
                                 input logic [7:0] c10, input logic [7:0] c11);
        chk({tag, "_c00"}, dot(A00, B00, A01, B10), c00);
        chk({tag, "_c01"}, dot(A00, B01, A01, B11), c01);
        chk({tag, "_c10"}, dot(A10, B00, A11, B10), c10);
        chk({tag, "_c11"}, dot(A10, B01, A11, B11), c11);
    endtask

    logic [DW-1:0] seq_inc [8];
    logic [DW-1:0] seq_alt [8];
    logic [DW-1:0] seq_max [8];

    initial begin
        seq_inc = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        seq_alt = '{4'd15, 4'd0, 4'd15, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
        seq_max = '{default: 4'd15};
        foreach (m_ops[i]) m_ops[i] = '0;

        // Test 1: reset for two cycles, then a basic load.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        stream(seq_inc);
        chk("t1_out_valid", out_valid, 1);
        check_product("t1", 8'd19, 8'd22, 8'd43, 8'd50);

        // Test 2: gapped load, long back-pressure, in_valid ignored in HOLD.
        release_set();
        for (int i = 0; i < 8; i++) begin
            send(seq_inc[i], 1'b1);
            send(4'($urandom_range(0, 15)), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        check_product("t2", 8'd19, 8'd22, 8'd43, 8'd50);

        // Test 3: release and reload.
        release_set();
        chk("t3_in_ready", in_ready, 1);
        stream(seq_alt);
        check_product("t3", 8'd15, 8'd15, 8'd15, 8'd15);

        // Test 4: abort mid-load. The element offered together with clr is lost.
        release_set();
        for (int i = 0; i < 3; i++) send(4'd9, 1'b1);
        clr = 1'b1;
        send(4'd9, 1'b1);
        clr = 1'b0;
        chk("t4_cnt_after_clr", elem_cnt, 0);
        stream(seq_inc);
        check_product("t4", 8'd19, 8'd22, 8'd43, 8'd50);

        // Test 5: clr and release in the same cycle while in HOLD.
        clr       = 1'b1;
        out_ready = 1'b1;
        tick();
        clr       = 1'b0;
        out_ready = 1'b0;
        chk("t5_out_valid", out_valid, 0);
        check_product("t5", 8'd19, 8'd22, 8'd43, 8'd50);

        // Test 6: reset while holding A=[1 2;3 4], then a full-scale load.
        stream(seq_inc);
        rst = 1'b1;
        tick();
        chk("t6_in_ready_in_rst", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("t6_in_ready_after", in_ready, 1);
        check_product("t6_zero", 8'd0, 8'd0, 8'd0, 8'd0);
        stream(seq_max);
        check_product("t6_max", 8'd194, 8'd194, 8'd194, 8'd194);

        // Randomized phase: random data, gaps, releases and rare aborts/resets.
        for (int i = 0; i < 400; i++) begin
            in_data   = 4'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            clr       = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst       = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
Upstream feeder for the 2x2 combinational matrix multiplier. It accepts matrix elements one at a time over a valid/ready stream and assembles them into the eight operand registers A00..B11. It then holds the operands stable and flags them valid until the downstream consumer acknowledges. This lets a narrow serial source (UART bridge, test sequencer) drive the parallel multiplier inputs.

Parameters:
DW, 4, element width in bits; must match the multiplier operand width.
NUM_ELEM, 8, elements per operand set (4 for A, 4 for B); fixed at 8, not for override.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
clr  input  1  synchronous soft abort: discards any partial or held operand set.
in_data  input  DW  element value.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader accepts an element this cycle.
A00, A01, A10, A11  output  DW each  matrix A operands, registered.
B00, B01, B10, B11  output  DW each  matrix B operands, registered.
out_valid  output  1  all eight operands loaded and stable.
out_ready  input  1  consumer has taken the operand set.
elem_cnt  output  3  index of the next element to be written (0..7).

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to LOAD, elem_cnt=0, all A/B registers=0, out_valid=0.
  - in_ready is forced to 0 while rst is high.
- Element order, elem_cnt 0..7: A00, A01, A10, A11, B00, B01, B10, B11. This is row-major, A before B.
- States:
  - LOAD: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
  - in_ready and out_valid are pure decodes of registered state (plus rst gating on in_ready). No combinational path from in_valid or out_ready.
- LOAD transfer:
  - A transfer occurs when in_valid and in_ready are both 1.
  - On a transfer, the register selected by elem_cnt takes in_data and elem_cnt increments.
  - If elem_cnt was 7, elem_cnt wraps to 0 and the state moves to HOLD. out_valid is 1 in the next cycle.
  - Latency: the 8th accepted element sets out_valid exactly 1 cycle later.
- Back-pressure: in_valid=0 gaps of any length are allowed. No register or counter changes without a transfer.
- HOLD:
  - All A/B outputs are frozen. in_data and in_valid are ignored.
  - When out_valid and out_ready are both 1 at an edge, the state moves to LOAD and in_ready=1 next cycle.
  - A/B registers keep their last values after release. They are overwritten element by element by the next load, not cleared.
- out_ready while in LOAD has no effect.
- Back-to-back sets: the minimum period is 8 load cycles + 1 HOLD cycle.
- clr=1 at an edge:
  - State goes to LOAD, elem_cnt=0, out_valid=0.
  - A/B registers are not cleared.
  - clr has priority over a simultaneous in or out handshake; that handshake is lost.
  - rst has priority over clr.
- Reset or clr mid-load: the partial set is discarded. The next accepted element is written to A00.
- Width: in_data is stored verbatim; no arithmetic, extension or saturation.
- Operand outputs connect directly to the multiplier's A/B inputs.

Test Plan:
1. Basic load:
   - Stimulus: rst for 2 cycles, then stream 1,2,3,4,5,6,7,8 with in_valid held high.
   - Required: in_ready=1 for 8 cycles. out_valid rises the cycle after the 8th transfer.
   - Required: A=[1 2;3 4], B=[5 6;7 8]. Attached multiplier gives C=[19 22;43 50].
2. Gapped input and back-pressure:
   - Stimulus: same data with in_valid toggling 1/0, then out_ready held 0 for 10 cycles.
   - Required: elem_cnt advances only on transfers. out_valid stays 1 and outputs stay stable for all 10 cycles.
   - Required: in_valid pulses during HOLD leave A/B unchanged.
3. Release and reload:
   - Stimulus: pulse out_ready for 1 cycle, then stream 15,0,15,0,1,1,1,1.
   - Required: out_valid=0 and in_ready=1 the next cycle.
   - Required: new set A=[15 0;15 0], B=[1 1;1 1]. Multiplier output is C=[15 15;15 15].
4. Abort mid-load:
   - Stimulus: load 3 elements (9,9,9), assert clr together with a 4th in_valid of value 9, then stream 1..8.
   - Required: the 4th element is not captured and elem_cnt=0 after clr.
   - Required: final A=[1 2;3 4], B=[5 6;7 8].
5. clr vs release priority:
   - Stimulus: in HOLD, assert clr and out_ready in the same cycle.
   - Required: next cycle LOAD, elem_cnt=0, out_valid=0. A/B still hold the prior values.
6. Reset mid-HOLD:
   - Stimulus: in HOLD with A=[1 2;3 4], assert rst for 1 cycle.
   - Required: all A/B=0, out_valid=0, in_ready=0 during rst and 1 the cycle after.
   - Required: a max-value load of all 15 gives C=[450 450;450 450] truncated by the multiplier to 8 bits (194), confirming the loader passes full DW-bit values.
